// File: rtl/cpu_pkg.sv
// Shared definitions for the pc sequencer: state encoding, fault causes and
// default vector constants.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_WAIT_ACK,
    ST_EXEC,
    ST_FAULT
  } seq_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_TIMEOUT  = 2'd1,
    CAUSE_MISALIGN = 2'd2
  } fault_cause_t;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_FAULT_VEC = 32'h0000_0180;
  localparam int unsigned DEFAULT_TIMEOUT   = 16;
  localparam int unsigned TIMER_W           = 8;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory request/acknowledge handshake between sequencer and memory.
interface pc_sequencer_if;
  logic        seq_imem_req;
  logic [31:0] seq_imem_addr;
  logic        seq_imem_ack;
  logic [31:0] seq_imem_data;

  modport master (
    output seq_imem_req, seq_imem_addr,
    input  seq_imem_ack, seq_imem_data
  );

  modport slave (
    input  seq_imem_req, seq_imem_addr,
    output seq_imem_ack, seq_imem_data
  );
endinterface

// File: rtl/fetch_timer.sv
// Saturating fetch-wait counter with clear/enable and a terminal-count flag.
module fetch_timer
  import cpu_pkg::*;
#(
  parameter int unsigned TC_VALUE = 14
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TC_VALUE[TIMER_W-1:0]);
endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch/execute controller steering the pc register, the imem
// handshake, instruction latching, retirement counting and fault vectoring.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
  parameter logic [31:0] FAULT_VEC = DEFAULT_FAULT_VEC,
  parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                  seq_clk,
  input  logic                  seq_rst_n,
  input  logic [31:0]           seq_pc_cur,
  output logic                  seq_pc_write,
  output logic [31:0]           seq_pc_next,
  pc_sequencer_if.master        imem,
  output logic [31:0]           seq_ir,
  output logic                  seq_ir_valid,
  input  logic                  seq_stall,
  input  logic                  seq_ex_done,
  input  logic                  seq_ex_redirect,
  input  logic [31:0]           seq_ex_target,
  output logic                  seq_fault,
  output logic [1:0]            seq_fault_cause,
  output logic [31:0]           seq_retired
);
  seq_state_t   state, state_nxt;
  fault_cause_t cause, new_cause;
  logic         tmr_clr, tmr_en, tmr_tc;
  logic         take_ir, retire, raise_fault;

  // Terminal count sits one below TIMEOUT-1 so FETCH..FAULT spans TIMEOUT cycles.
  fetch_timer #(.TC_VALUE(TIMEOUT - 2)) u_timer (
    .clk   (seq_clk),
    .rst_n (seq_rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  assign imem.seq_imem_addr = seq_pc_cur;

  always_comb begin
    state_nxt         = state;
    seq_pc_write      = 1'b1;
    seq_pc_next       = seq_pc_cur;
    imem.seq_imem_req = 1'b0;
    tmr_clr           = 1'b0;
    tmr_en            = 1'b0;
    take_ir           = 1'b0;
    retire            = 1'b0;
    raise_fault       = 1'b0;
    new_cause         = CAUSE_NONE;
    case (state)
      ST_BOOT: begin
        seq_pc_next = RESET_VEC;
        state_nxt   = ST_FETCH;
      end
      ST_FETCH: begin
        imem.seq_imem_req = 1'b1;
        if (!seq_stall) begin
          tmr_clr = 1'b1;
          if (imem.seq_imem_ack) begin
            take_ir   = 1'b1;
            state_nxt = ST_EXEC;
          end else begin
            state_nxt = ST_WAIT_ACK;
          end
        end
      end
      ST_WAIT_ACK: begin
        imem.seq_imem_req = 1'b1;
        if (!seq_stall) begin
          if (imem.seq_imem_ack) begin
            take_ir   = 1'b1;
            state_nxt = ST_EXEC;
          end else if (tmr_tc) begin
            raise_fault = 1'b1;
            new_cause   = CAUSE_TIMEOUT;
            state_nxt   = ST_FAULT;
          end else begin
            tmr_en = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (!seq_stall && seq_ex_done) begin
          if (!seq_ex_redirect) begin
            seq_pc_write = 1'b0;
            retire       = 1'b1;
            state_nxt    = ST_FETCH;
          end else if (seq_ex_target[1:0] == 2'b00) begin
            seq_pc_next = seq_ex_target;
            retire      = 1'b1;
            state_nxt   = ST_FETCH;
          end else begin
            raise_fault = 1'b1;
            new_cause   = CAUSE_MISALIGN;
            state_nxt   = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        if (!seq_stall) begin
          seq_pc_next = FAULT_VEC;
          state_nxt   = ST_FETCH;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge seq_clk or negedge seq_rst_n) begin
    if (!seq_rst_n) state <= ST_BOOT;
    else            state <= state_nxt;
  end

  always_ff @(posedge seq_clk or negedge seq_rst_n) begin
    if (!seq_rst_n) begin
      seq_ir       <= '0;
      seq_ir_valid <= 1'b0;
      seq_fault    <= 1'b0;
      cause        <= CAUSE_NONE;
      seq_retired  <= '0;
    end else begin
      seq_ir_valid <= take_ir;
      if (take_ir) seq_ir <= imem.seq_imem_data;
      if (retire) seq_retired <= seq_retired + 32'd1;
      if (raise_fault) begin
        seq_fault <= 1'b1;
        if (cause == CAUSE_NONE) cause <= new_cause;
      end
    end
  end

  assign seq_fault_cause = cause;
endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against an instruction-level model of
// fetch address, retirement count and fault state.
module tb_pc_sequencer;
  localparam logic [31:0] RST_V = 32'h0000_0100;
  localparam logic [31:0] FLT_V = 32'h0000_0180;
  localparam int unsigned TMO   = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_cur = '0;
  logic        pc_write;
  logic [31:0] pc_next;
  logic [31:0] ir;
  logic        ir_valid;
  logic        stall = 1'b0;
  logic        ex_done = 1'b0;
  logic        ex_redirect = 1'b0;
  logic [31:0] ex_target = '0;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] retired;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned fetch_cyc = 0;

  logic [31:0] m_pc, m_ret;
  logic        m_fault;
  logic [1:0]  m_cause;

  pc_sequencer_if imem();

  pc_sequencer #(.RESET_VEC(RST_V), .FAULT_VEC(FLT_V), .TIMEOUT(TMO)) dut (
    .seq_clk         (clk),
    .seq_rst_n       (rst_n),
    .seq_pc_cur      (pc_cur),
    .seq_pc_write    (pc_write),
    .seq_pc_next     (pc_next),
    .imem            (imem),
    .seq_ir          (ir),
    .seq_ir_valid    (ir_valid),
    .seq_stall       (stall),
    .seq_ex_done     (ex_done),
    .seq_ex_redirect (ex_redirect),
    .seq_ex_target   (ex_target),
    .seq_fault       (fault),
    .seq_fault_cause (fault_cause),
    .seq_retired     (retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // The pc register: loads on write, otherwise advances by 4 every falling edge
  always @(negedge clk) pc_cur <= pc_write ? pc_next : pc_cur + 32'd4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (imem.seq_imem_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("wait_req", 32'd0, 32'd1);
  endtask

  task automatic do_fetch(input int unsigned lat, input bit allow_stall);
    logic [31:0] data;
    int unsigned waited;
    bit ok, acc;
    data   = $urandom();
    waited = 0;
    acc    = 1'b0;
    wait_fetch(ok);
    if (!ok) return;
    fetch_cyc = cyc;
    chk("fetch_addr", imem.seq_imem_addr, m_pc);
    chk("retired", retired, m_ret);
    chk("fault", fault, m_fault);
    chk("cause", fault_cause, m_cause);
    for (int i = 0; i < 64 && !acc; i++) begin
      stall = allow_stall && ($urandom_range(0, 3) == 0);
      imem.seq_imem_ack  = (waited >= lat);
      imem.seq_imem_data = imem.seq_imem_ack ? data : $urandom();
      #1;
      chk("fetch_req", imem.seq_imem_req, 1);
      chk("fetch_wr", pc_write, 1);
      chk("fetch_hold", pc_next, pc_cur);
      chk("ir_valid_lo", ir_valid, 0);
      acc = imem.seq_imem_ack && !stall;
      if (!stall) waited++;
      tick();
    end
    imem.seq_imem_ack = 1'b0;
    stall = 1'b0;
    chk("ir_valid", ir_valid, 1);
    chk("ir", ir, data);
  endtask

  // kind: 0 = sequential, 1 = aligned redirect, 2 = misaligned redirect
  task automatic do_exec(input int unsigned lat, input int unsigned kind,
                         input logic [31:0] target, input bit allow_stall);
    int unsigned waited;
    bit acc;
    waited = 0;
    acc    = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) begin
      stall       = allow_stall && ($urandom_range(0, 3) == 0);
      ex_done     = (waited >= lat);
      ex_redirect = ex_done && (kind != 0);
      ex_target   = ex_redirect ? target : $urandom();
      #1;
      chk("exec_req", imem.seq_imem_req, 0);
      acc = ex_done && !stall;
      if (acc && kind == 0) begin
        chk("exec_inc", pc_write, 0);
      end else if (acc && kind == 1) begin
        chk("exec_wr", pc_write, 1);
        chk("exec_tgt", pc_next, target);
      end else begin
        chk("exec_wr", pc_write, 1);
        chk("exec_hold", pc_next, pc_cur);
      end
      if (!stall) waited++;
      tick();
    end
    ex_done = 1'b0;
    ex_redirect = 1'b0;
    stall = 1'b0;
    #1;
    case (kind)
      0: begin m_pc = m_pc + 32'd4; m_ret = m_ret + 32'd1; end
      1: begin m_pc = target;       m_ret = m_ret + 32'd1; end
      default: begin
        m_pc = FLT_V;
        m_fault = 1'b1;
        if (m_cause == 2'd0) m_cause = 2'd2;
        chk("flt_flag", fault, 1);
        chk("flt_cause", fault_cause, m_cause);
        chk("flt_vec", pc_next, FLT_V);
      end
    endcase
    chk("ir_valid_drop", ir_valid, 0);
    chk("retired_now", retired, m_ret);
  endtask

  task automatic do_timeout();
    int unsigned n;
    bit ok;
    n = 0;
    imem.seq_imem_ack = 1'b0;
    stall = 1'b0;
    wait_fetch(ok);
    if (!ok) return;
    chk("tmo_addr", imem.seq_imem_addr, m_pc);
    while (imem.seq_imem_req && n < 4 * TMO) begin
      n++;
      tick();
    end
    chk("tmo_cycles", n, TMO);
    m_fault = 1'b1;
    m_pc    = FLT_V;
    if (m_cause == 2'd0) m_cause = 2'd1;
    #1;
    chk("tmo_fault", fault, 1);
    chk("tmo_cause", fault_cause, m_cause);
    chk("tmo_vec", pc_next, FLT_V);
  endtask

  task automatic model_reset();
    m_pc    = RST_V;
    m_ret   = '0;
    m_fault = 1'b0;
    m_cause = 2'd0;
  endtask

  task automatic check_reset_vals();
    chk("rst_req", imem.seq_imem_req, 0);
    chk("rst_wr", pc_write, 1);
    chk("rst_next", pc_next, RST_V);
    chk("rst_ir", ir, 0);
    chk("rst_irv", ir_valid, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cause", fault_cause, 0);
    chk("rst_ret", retired, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int unsigned prev, r, lat;
    logic [31:0] p;
    imem.seq_imem_ack  = 1'b0;
    imem.seq_imem_data = '0;
    model_reset();
    prev = 0;

    tick();
    tick();
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("boot_pc", pc_cur, RST_V);

    // Back-to-back sequential instructions
    for (int i = 0; i < 3; i++) begin
      do_fetch(0, 1'b0);
      if (i > 0) chk("instr_span", fetch_cyc - prev + 1, 3);
      prev = fetch_cyc;
      do_exec(0, 0, '0, 1'b0);
    end
    chk("retired3", retired, 32'd3);

    do_fetch(1, 1'b0);
    do_exec(1, 1, 32'h0000_2000, 1'b0);
    do_fetch(0, 1'b0);
    do_exec(0, 2, 32'h0000_2002, 1'b0);
    do_timeout();

    // Reset in the middle of WAIT_ACK with an ack arriving
    wait_fetch(ok);
    imem.seq_imem_ack = 1'b0;
    tick();
    tick();
    chk("mid_req_pre", imem.seq_imem_req, 1);
    imem.seq_imem_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    tick();
    tick();
    imem.seq_imem_ack = 1'b0;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    chk("reboot_pc", pc_cur, RST_V);

    do_timeout();

    // Done held through a five-cycle stall is taken exactly once
    do_fetch(0, 1'b0);
    p = pc_cur;
    ex_done = 1'b1;
    ex_redirect = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_pc", pc_cur, p);
      chk("stall_ret", retired, m_ret);
    end
    stall = 1'b0;
    do_exec(0, 0, '0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      r   = $urandom_range(0, 19);
      lat = $urandom_range(0, 3);
      if (r == 0) begin
        do_timeout();
      end else begin
        do_fetch($urandom_range(0, 4), 1'b1);
        if (r <= 2)
          do_exec(lat, 2, ($urandom() & ~32'd3) | 32'($urandom_range(1, 3)), 1'b1);
        else if (r <= 8)
          do_exec(lat, 1, $urandom() & ~32'd3, 1'b1);
        else
          do_exec(lat, 0, '0, 1'b1);
      end
    end
    do_fetch(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
